// File: rtl/memory_cycle.sv
// memory_cycle: memory access stage. Holds the data memory, performs
// stores, reads combinationally, and registers the writeback-stage values.
// Optional load/store performance counters are enabled by defining
// MEM_PERF_COUNT_EN.
module memory_cycle #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
`ifdef MEM_PERF_COUNT_EN
  output logic [31:0] LoadCountM,
  output logic [31:0] StoreCountM,
`endif
  output logic [31:0] ResultW
);

  localparam int IDX_W = $clog2(DMEM_DEPTH);

  logic [31:0]      dmem [DMEM_DEPTH];
  logic [IDX_W-1:0] wordIdx;
  logic [31:0]      readData;

  // Byte offset and bits above the index are dropped, so addresses wrap.
  assign wordIdx  = ALU_ResultM[IDX_W+1:2];
  // Read happens before the edge, so a colliding store returns old data.
  assign readData = dmem[wordIdx];

  // Data memory: cleared while in reset, store on edge otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (MemWriteM) begin
      dmem[wordIdx] <= WriteDataM;
    end
  end

  // M->W pipeline register; RD_W=0 is passed through untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RD_W        <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= readData;
      PCPlus4W    <= PCPlus4M;
    end
  end

  // Writeback result select; also feeds the forwarding path.
  always_comb begin
    ResultW = '0;
    case (ResultSrcW)
      2'b00:   ResultW = ALU_ResultW;
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = '0;
    endcase
  end

`ifdef MEM_PERF_COUNT_EN
  // Saturating load/store event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LoadCountM  <= '0;
      StoreCountM <= '0;
    end else begin
      if (RegWriteM && ResultSrcM == 2'b01 && LoadCountM != 32'hFFFF_FFFF)
        LoadCountM <= LoadCountM + 32'd1;
      if (MemWriteM && StoreCountM != 32'hFFFF_FFFF)
        StoreCountM <= StoreCountM + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle with a word-array reference model.
module tb_memory_cycle;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [4:0]  RD_M = '0;
  logic [31:0] ALU_ResultM = '0, WriteDataM = '0, PCPlus4M = '0;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W, ResultW;
`ifdef MEM_PERF_COUNT_EN
  logic [31:0] LoadCountM, StoreCountM;
  logic [31:0] expLoad, expStore;
`endif

  int nCmp = 0;
  int nErr = 0;

  // reference model state and expected W-stage values
  logic [31:0] model [DEPTH];
  logic        expRw;
  logic [1:0]  expRs;
  logic [4:0]  expRd;
  logic [31:0] expAlu, expRead, expPc, expRes;

  memory_cycle #(.DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
`ifdef MEM_PERF_COUNT_EN
    .LoadCountM(LoadCountM), .StoreCountM(StoreCountM),
`endif
    .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  function automatic int wordOf(logic [31:0] a);
    return int'((a % (DEPTH * 4)) / 4);
  endfunction

  // Drive one M-stage transaction, update the model, step past the edge.
  task automatic cycle(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    expRw = rw; expRs = rs; expRd = rd; expAlu = alu; expPc = pc;
    expRead = model[wordOf(alu)];
    if (mw) model[wordOf(alu)] = wd;
    expRes = (rs == 2'd0) ? alu : (rs == 2'd1) ? expRead : (rs == 2'd2) ? pc : 32'd0;
`ifdef MEM_PERF_COUNT_EN
    if (rw && rs == 2'd1 && expLoad != 32'hFFFF_FFFF) expLoad++;
    if (mw && expStore != 32'hFFFF_FFFF) expStore++;
`endif
    @(posedge clk); #1;
    MemWriteM = 1'b0; RegWriteM = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`ifdef MEM_PERF_COUNT_EN
    expLoad = '0; expStore = '0;
`endif
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`ifdef MEM_PERF_COUNT_EN
    expLoad = '0; expStore = '0;
`endif
    rst = 1'b0;
    RegWriteM = 1'b1; ResultSrcM = 2'b10; RD_M = 5'd7; ALU_ResultM = 32'h55;
    PCPlus4M = 32'h99; MemWriteM = 1'b1; WriteDataM = 32'h1234;
    @(posedge clk); @(posedge clk); #1;
    nCmp++; if (RegWriteW !== 1'b0) begin nErr++; $display("FAIL reset_rw got %0b want 0", RegWriteW); end
    nCmp++; if (ResultSrcW !== 2'b00) begin nErr++; $display("FAIL reset_rs got %0b want 0", ResultSrcW); end
    nCmp++; if (RD_W !== 5'd0) begin nErr++; $display("FAIL reset_rd got %0d want 0", RD_W); end
    nCmp++; if ({ALU_ResultW, ReadDataW, PCPlus4W} !== 96'd0) begin nErr++;
      $display("FAIL reset_data got %h %h %h want 0", ALU_ResultW, ReadDataW, PCPlus4W); end
    nCmp++; if (ResultW !== 32'd0) begin nErr++; $display("FAIL reset_result got %h want 0", ResultW); end
    MemWriteM = 1'b0; RegWriteM = 1'b0; ResultSrcM = '0; RD_M = '0;
    @(negedge clk); rst = 1'b1;
    // store attempted during reset must not have landed at 0x54
    cycle(1, 0, 2'b01, 5'd1, 32'h54, 0, 0);
    nCmp++; if (ReadDataW !== 32'd0) begin nErr++; $display("FAIL reset_store_ignored got %h want 0", ReadDataW); end
  endtask

  task automatic test_store_load();
    cycle(0, 1, 2'b00, 5'd0, 32'h10, 32'hDEAD_BEEF, 32'h0);
    cycle(1, 0, 2'b01, 5'd3, 32'h10, 32'h0, 32'h0);
    nCmp++; if (ReadDataW !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL store_load_read got %h want deadbeef", ReadDataW); end
    nCmp++; if (ResultW !== 32'hDEAD_BEEF) begin nErr++; $display("FAIL store_load_result got %h want deadbeef", ResultW); end
    nCmp++; if (RegWriteW !== 1'b1 || RD_W !== 5'd3) begin nErr++;
      $display("FAIL store_load_ctrl got %0b/%0d want 1/3", RegWriteW, RD_W); end
  endtask

  task automatic test_collision();
    cycle(0, 1, 2'b00, 5'd0, 32'h20, 32'h1111_1111, 32'h0);
    cycle(1, 1, 2'b01, 5'd4, 32'h20, 32'h2222_2222, 32'h0);
    nCmp++; if (ReadDataW !== 32'h1111_1111) begin nErr++; $display("FAIL collision_old got %h want 11111111", ReadDataW); end
    cycle(1, 0, 2'b01, 5'd4, 32'h20, 32'h0, 32'h0);
    nCmp++; if (ReadDataW !== 32'h2222_2222) begin nErr++; $display("FAIL collision_new got %h want 22222222", ReadDataW); end
  endtask

  task automatic test_result_mux();
    cycle(1, 0, 2'b00, 5'd5, 32'd5, 32'h0, 32'h104);
    nCmp++; if (ResultW !== 32'd5) begin nErr++; $display("FAIL mux_alu got %h want 5", ResultW); end
    cycle(1, 0, 2'b10, 5'd5, 32'd5, 32'h0, 32'h104);
    nCmp++; if (ResultW !== 32'h104) begin nErr++; $display("FAIL mux_pc4 got %h want 104", ResultW); end
    cycle(1, 0, 2'b11, 5'd5, 32'd5, 32'h0, 32'h104);
    nCmp++; if (ResultW !== 32'd0) begin nErr++; $display("FAIL mux_zero got %h want 0", ResultW); end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 2'b00, 5'd0, 32'h400, 32'hA5A5_A5A5, 32'h0);
    cycle(1, 0, 2'b01, 5'd6, 32'h000, 32'h0, 32'h0);
    nCmp++; if (ReadDataW !== 32'hA5A5_A5A5) begin nErr++; $display("FAIL wrap got %h want a5a5a5a5", ReadDataW); end
    cycle(1, 0, 2'b01, 5'd6, 32'h3, 32'h0, 32'h0);
    nCmp++; if (ReadDataW !== 32'hA5A5_A5A5) begin nErr++; $display("FAIL wrap_offset got %h want a5a5a5a5", ReadDataW); end
  endtask

  task automatic test_reset_midstream();
    cycle(1, 0, 2'b00, 5'd9, 32'h77, 32'h0, 32'h8);
    nCmp++; if (RegWriteW !== 1'b1) begin nErr++; $display("FAIL midrst_pre got %0b want 1", RegWriteW); end
    #2 rst = 1'b0;
    #1;
    nCmp++; if (RegWriteW !== 1'b0 || ALU_ResultW !== 32'd0) begin nErr++;
      $display("FAIL midrst_async got rw=%0b alu=%h want 0/0", RegWriteW, ALU_ResultW); end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
`ifdef MEM_PERF_COUNT_EN
    expLoad = '0; expStore = '0;
`endif
    @(negedge clk); rst = 1'b1;
    cycle(1, 0, 2'b01, 5'd2, 32'h10, 32'h0, 32'h0);
    nCmp++; if (ReadDataW !== 32'd0) begin nErr++; $display("FAIL midrst_cleared got %h want 0", ReadDataW); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      // small word window plus random high bits so hits and wraps are common
      a = {$urandom_range(3, 0) == 0 ? $urandom() : 32'd0} & 32'hFFFF_FC00;
      a = a | ($urandom_range(15, 0) << 2) | $urandom_range(3, 0);
      cycle($urandom_range(1, 0), $urandom_range(1, 0), 2'($urandom_range(3, 0)),
            5'($urandom_range(31, 0)), a, $urandom(), $urandom());
      nCmp++; if ({RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W} !==
                  {expRw, expRs, expRd, expAlu, expPc}) begin nErr++;
        $display("FAIL rand_ctrl[%0d] got %0b %0d %0d %h %h want %0b %0d %0d %h %h", n,
                 RegWriteW, ResultSrcW, RD_W, ALU_ResultW, PCPlus4W, expRw, expRs, expRd, expAlu, expPc); end
      nCmp++; if (ReadDataW !== expRead) begin nErr++;
        $display("FAIL rand_read[%0d] got %h want %h", n, ReadDataW, expRead); end
      nCmp++; if (ResultW !== expRes) begin nErr++;
        $display("FAIL rand_result[%0d] got %h want %h", n, ResultW, expRes); end
`ifdef MEM_PERF_COUNT_EN
      nCmp++; if (LoadCountM !== expLoad || StoreCountM !== expStore) begin nErr++;
        $display("FAIL rand_counts[%0d] got %0d/%0d want %0d/%0d", n, LoadCountM, StoreCountM, expLoad, expStore); end
`endif
    end
  endtask

`ifdef MEM_PERF_COUNT_EN
  task automatic test_counters();
    applyReset();
    for (int i = 0; i < 3; i++) cycle(0, 1, 2'b00, 5'd0, 32'(i * 4), 32'(i), 32'h0);
    for (int i = 0; i < 2; i++) cycle(1, 0, 2'b01, 5'd1, 32'(i * 4), 32'h0, 32'h0);
    cycle(1, 0, 2'b00, 5'd1, 32'h0, 32'h0, 32'h0);
    nCmp++; if (StoreCountM !== 32'd3) begin nErr++; $display("FAIL cnt_store got %0d want 3", StoreCountM); end
    nCmp++; if (LoadCountM !== 32'd2) begin nErr++; $display("FAIL cnt_load got %0d want 2", LoadCountM); end
    force dut.StoreCountM = 32'hFFFF_FFFF;
    #1 release dut.StoreCountM;
    cycle(0, 1, 2'b00, 5'd0, 32'h8, 32'h5, 32'h0);
    nCmp++; if (StoreCountM !== 32'hFFFF_FFFF) begin nErr++; $display("FAIL cnt_sat got %h want ffffffff", StoreCountM); end
    expStore = 32'hFFFF_FFFF;
  endtask
`endif

  initial begin
    test_reset();
    test_store_load();
    test_collision();
    test_result_mux();
    test_wrap();
    test_reset_midstream();
`ifdef MEM_PERF_COUNT_EN
    test_counters();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", nCmp);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have parameter DMEM_DEPTH, default 256, meaning number of 32-bit data-memory words; power of two, 4..1024.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have inputs RegWriteM 1, MemWriteM 1, ResultSrcM 2, RD_M 5: control and destination register from the execute-stage register.
REQ-005 SHALL have inputs ALU_ResultM 32, WriteDataM 32, PCPlus4M 32: address/ALU value, store data, return address from the execute-stage register.
REQ-006 SHALL have outputs RegWriteW 1, ResultSrcW 2, RD_W 5: registered writeback control.
REQ-007 SHALL have outputs ALU_ResultW 32, ReadDataW 32, PCPlus4W 32: registered writeback data.
REQ-008 SHALL have output ResultW 32: combinational writeback result, also the forwarding source for execute.

Function
REQ-009 SHALL hold a DMEM_DEPTH x 32 data memory, word-indexed by ALU_ResultM[log2(DMEM_DEPTH)+1:2].
- Address bits [1:0] ignored (no misalignment trap).
- Bits above the index ignored; addresses wrap modulo DMEM_DEPTH*4.
REQ-010 SHALL write WriteDataM to the indexed word on the rising clk edge when MemWriteM=1 and rst=1.
REQ-011 SHALL read the indexed word combinationally every cycle, independent of MemWriteM.
REQ-012 SHALL capture the pre-write contents into ReadDataW when a store and a read hit the same word in the same cycle.
- A load in the cycle after a store to the same word returns the new data.
REQ-013 SHALL register RegWriteM, ResultSrcM, RD_M, ALU_ResultM, read data and PCPlus4M into the W outputs on every rising edge; latency M->W is exactly 1 cycle.
REQ-014 SHALL drive ResultW from ResultSrcW: 00 ALU_ResultW, 01 ReadDataW, 10 PCPlus4W, 11 32'h00000000.
REQ-015 SHALL NOT gate RegWriteW for RD_W=0; x0 write suppression is the register file's responsibility.

Reset
REQ-016 SHALL, while rst=0, force RegWriteW=0, ResultSrcW=00, RD_W=0, and ALU_ResultW, ReadDataW, PCPlus4W all 0; ResultW then reads 0.
REQ-017 SHALL clear every data-memory word to 32'h00000000 while rst=0.
REQ-018 SHALL ignore a store whose edge coincides with rst=0; the first accepted store is on the first rising edge with rst=1.
REQ-019 SHALL, on reset asserted mid-operation, discard all in-flight W-register contents immediately, without waiting for clk.

Configuration
REQ-020 SHALL, with macro MEM_PERF_COUNT_EN defined, add outputs LoadCountM 32 and StoreCountM 32, both reset to 0.
- LoadCountM increments each edge with RegWriteM=1 and ResultSrcM=01.
- StoreCountM increments each edge with MemWriteM=1.
- Both saturate at 32'hFFFFFFFF.
REQ-021 SHALL, without MEM_PERF_COUNT_EN, omit both ports and all counter logic; all other behaviour is identical.

Verification
REQ-022 SHALL cover store then load: MemWriteM=1, ALU_ResultM=0x10, WriteDataM=0xDEADBEEF; next cycle RegWriteM=1, ResultSrcM=01, same address -> one cycle later ReadDataW=0xDEADBEEF, ResultW=0xDEADBEEF.
REQ-023 SHALL cover same-cycle collision: word 0x20 holds 0x11111111; store 0x22222222 to 0x20 with a read in the same cycle -> ReadDataW=0x11111111; the following read -> 0x22222222.
REQ-024 SHALL cover the result mux: ALU_ResultM=5, PCPlus4M=0x104, ResultSrcM stepped 00, 10, 11 -> ResultW=5, 0x104, 0 on successive cycles.
REQ-025 SHALL cover wrap: DMEM_DEPTH=256, store 0xA5A5A5A5 at 0x400 -> a load at 0x000 returns 0xA5A5A5A5.
REQ-026 SHALL cover reset mid-stream: rst=0 between edges while RegWriteW=1 -> RegWriteW=0 immediately; after rst=1, a load from 0x10 returns 0.
REQ-027 SHALL cover counters with MEM_PERF_COUNT_EN: 3 stores and 2 loads -> StoreCountM=3, LoadCountM=2; preload 0xFFFFFFFF and store -> value holds at 0xFFFFFFFF.
